// File: rtl/gh_pkg.sv
// Shared game-state encoding and keyboard keycode constants for the beat front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gh_pkg;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_RUN   = 2'd1,
    GS_PAUSE = 2'd2
  } game_state_t;

  // Scan-style keycodes as delivered by the keyboard front end
  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_SPACE = 8'h2c;
  localparam logic [7:0] KC_1     = 8'h1e;
  localparam logic [7:0] KC_2     = 8'h1f;
  localparam logic [7:0] KC_3     = 8'h20;
  localparam logic [7:0] KC_4     = 8'h21;
  localparam logic [7:0] KC_P     = 8'h13;

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-TICK_PERIOD counter; tick flags the wrap cycle.
// Latency: tick is combinational, high in the cycle the counter sits at TICK_PERIOD-1 with en.
// Backpressure: none; en freezes the count, clr zeroes it.
module tick_gen #(
  parameter int TICK_PERIOD = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled, wrap on the last phase, clear has priority over counting
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beat_clock_lanes.sv
// Game timing (scroll tick, beat count, IDLE/RUN/PAUSE) and keycode-to-lane decode.
// Latency: all outputs registered, one cycle from keycode/start_/end_; first shift TICK_PERIOD cycles into RUN.
// Backpressure: none; inputs are sampled every cycle and never stalled.
module beat_clock_lanes
  import gh_pkg::*;
#(
  parameter int                     TICK_PERIOD = 10_000_000,
  parameter int                     CNT_W       = 24,
  parameter int                     NUM_LANES   = 4,
  parameter logic [NUM_LANES*8-1:0] LANE_KEYS   = {KC_4, KC_3, KC_2, KC_1},
  parameter logic [7:0]             PAUSE_KEY   = KC_P,
  parameter logic [7:0]             SPACE_KEY   = KC_SPACE,
  parameter int                     BEAT_W      = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start_,
  input  logic                 end_,
  input  logic [7:0]           keycode,
  output logic                 shift,
  output logic [BEAT_W-1:0]    beat,
  output logic                 running,
  output logic                 paused,
  output logic                 space,
  output logic [NUM_LANES-1:0] lane_hold,
  output logic [NUM_LANES-1:0] lane_press
);

  game_state_t          state, state_nxt;
  logic                 pause_q;
  logic                 pause_edge;
  logic                 run_nxt;
  logic                 start_go;
  logic                 tick;
  logic [NUM_LANES-1:0] lane_match;

  // A held pause key toggles only once: act on its first cycle
  assign pause_edge = (keycode == PAUSE_KEY) && !pause_q;
  assign run_nxt    = (state_nxt == GS_RUN);
  assign start_go   = (state == GS_IDLE) && run_nxt;

  // Next-state: end_ wins over everything, start_ only from IDLE, pause edge toggles RUN/PAUSE
  always_comb begin
    state_nxt = state;
    if (end_) begin
      state_nxt = GS_IDLE;
    end else begin
      case (state)
        GS_IDLE:  if (start_)     state_nxt = GS_RUN;
        GS_RUN:   if (pause_edge) state_nxt = GS_PAUSE;
        GS_PAUSE: if (pause_edge) state_nxt = GS_RUN;
        default:                  state_nxt = GS_IDLE;
      endcase
    end
  end

  // State register and previous-cycle pause key sample
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= GS_IDLE;
      pause_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pause_q <= (keycode == PAUSE_KEY);
    end
  end

  assign running = (state == GS_RUN);
  assign paused  = (state == GS_PAUSE);

  // Phase only advances on cycles that stay in RUN, so a tick can never land on a
  // cycle that leaves RUN and the phase is preserved exactly across a pause
  tick_gen #(
    .TICK_PERIOD (TICK_PERIOD),
    .CNT_W       (CNT_W)
  ) u_tick_gen (
    .Clk   (Clk),
    .Reset (Reset),
    .en    ((state == GS_RUN) && run_nxt),
    .clr   (state_nxt == GS_IDLE),
    .tick  (tick)
  );

  // Scroll pulse and beat count move together so beat is already updated when shift is seen
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift <= 1'b0;
      beat  <= '0;
    end else begin
      shift <= tick;
      if (start_go) begin
        beat <= '0;
      end else if (tick) begin
        beat <= beat + 1'b1;
      end
    end
  end

  // Per-lane keycode compare; duplicate keys simply light several lanes
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_match[i] = (keycode == LANE_KEYS[i*8 +: 8]);
  end

  // Key levels plus press pulses on the hold rising edge, only while the game will be running
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lane_hold  <= '0;
      lane_press <= '0;
      space      <= 1'b0;
    end else begin
      lane_hold  <= lane_match;
      lane_press <= lane_match & ~lane_hold & {NUM_LANES{run_nxt}};
      space      <= (keycode == SPACE_KEY);
    end
  end

endmodule

// File: tb/tb_beat_clock_lanes.sv
module tb_beat_clock_lanes;

  localparam int TP = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start_ = 1'b0;
  logic       end_ = 1'b0;
  logic [7:0] keycode = 8'h00;

  logic        shift, running, paused, space;
  logic [15:0] beat;
  logic [3:0]  lane_hold, lane_press;

  logic        shift2, running2, paused2, space2;
  logic [1:0]  beat2;
  logic [3:0]  lane_hold2, lane_press2;

  int checks = 0;
  int errors = 0;

  logic [7:0] lane_key [4] = '{8'h1e, 8'h1f, 8'h20, 8'h21};

  always #5 Clk = ~Clk;

  beat_clock_lanes #(
    .TICK_PERIOD (TP), .CNT_W (3), .NUM_LANES (4), .BEAT_W (16)
  ) dut (
    .Clk (Clk), .Reset (Reset), .start_ (start_), .end_ (end_), .keycode (keycode),
    .shift (shift), .beat (beat), .running (running), .paused (paused),
    .space (space), .lane_hold (lane_hold), .lane_press (lane_press)
  );

  beat_clock_lanes #(
    .TICK_PERIOD (TP), .CNT_W (3), .NUM_LANES (4), .BEAT_W (2)
  ) dut2 (
    .Clk (Clk), .Reset (Reset), .start_ (start_), .end_ (end_), .keycode (keycode),
    .shift (shift2), .beat (beat2), .running (running2), .paused (paused2),
    .space (space2), .lane_hold (lane_hold2), .lane_press (lane_press2)
  );

  // Reference model: mode 0=idle 1=run 2=pause; phase counts run cycles since start,
  // a scroll tick happens whenever phase reaches a multiple of TP; beat = ticks seen.
  int       m_mode = 0;
  int       m_phase = 0;
  int       m_ticks = 0;
  bit       m_prevp = 0;
  bit       m_shift = 0;
  bit       m_space = 0;
  bit [3:0] m_hold = 0;
  bit [3:0] m_press = 0;

  task automatic model_update();
    bit       pedge;
    int       nmode;
    bit [3:0] match;
    for (int i = 0; i < 4; i++) match[i] = (keycode == lane_key[i]);
    if (Reset) begin
      m_mode = 0; m_phase = 0; m_ticks = 0; m_prevp = 0;
      m_shift = 0; m_space = 0; m_hold = 0; m_press = 0;
    end else begin
      pedge = (keycode == 8'h13) && !m_prevp;
      nmode = m_mode;
      if (end_) nmode = 0;
      else if (m_mode == 0 && start_) nmode = 1;
      else if (m_mode != 0 && pedge) nmode = (m_mode == 1) ? 2 : 1;
      m_shift = 0;
      if (m_mode == 0 && nmode == 1) begin
        m_phase = 0;
        m_ticks = 0;
      end else if (m_mode == 1 && nmode == 1) begin
        m_phase++;
        if (m_phase % TP == 0) begin
          m_shift = 1;
          m_ticks++;
        end
      end else if (nmode == 0) begin
        m_phase = 0;
      end
      m_press = (nmode == 1) ? (match & ~m_hold) : 4'b0000;
      m_hold  = match;
      m_space = (keycode == 8'h2c);
      m_prevp = (keycode == 8'h13);
      m_mode  = nmode;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start_ = 1'b1; keycode = 8'h1e;
    step(); step();
    checks++;
    if ({running, paused, shift, beat, space, lane_hold, lane_press} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {running, paused, shift, beat, space, lane_hold, lane_press});
    end
    checks++;
    if ({running2, paused2, shift2, beat2, space2, lane_hold2, lane_press2} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state2: got %h expected 0", {running2, paused2, shift2, beat2, space2, lane_hold2, lane_press2});
    end
    Reset = 1'b0; start_ = 1'b0; keycode = 8'h00;
    step();
  endtask

  task automatic test_start_ticks();
    start_ = 1'b1; step(); start_ = 1'b0;
    checks++;
    if (running !== 1'b1 || paused !== 1'b0) begin
      errors++;
      $display("FAIL start_running: running=%b paused=%b expected 1 0", running, paused);
    end
    for (int t = 1; t <= 3; t++) begin
      for (int c = 1; c <= TP; c++) begin
        step();
        checks++;
        if ({shift, beat} !== {(c == TP), (c == TP) ? 16'(t) : 16'(t - 1)}) begin
          errors++;
          $display("FAIL tick_%0d_%0d: shift=%b beat=%0d expected %b %0d", t, c, shift, beat,
                   (c == TP), (c == TP) ? t : t - 1);
        end
      end
    end
  endtask

  task automatic test_pause();
    end_ = 1'b1; step(); end_ = 1'b0;
    start_ = 1'b1; step(); start_ = 1'b0;
    repeat (5) step();
    keycode = 8'h13;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({running, paused, shift, beat} !== {1'b0, 1'b1, 1'b0, 16'd1}) begin
        errors++;
        $display("FAIL pause_hold_%0d: run=%b pause=%b shift=%b beat=%0d expected 0 1 0 1",
                 c, running, paused, shift, beat);
      end
    end
    keycode = 8'h00; step();
    keycode = 8'h13; step(); keycode = 8'h00;
    checks++;
    if ({running, paused, beat} !== {1'b1, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL resume: run=%b pause=%b beat=%0d expected 1 0 1", running, paused, beat);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if ({shift, beat} !== {(c == 3), (c == 3) ? 16'd2 : 16'd1}) begin
        errors++;
        $display("FAIL resume_phase_%0d: shift=%b beat=%0d expected %b %0d", c, shift, beat,
                 (c == 3), (c == 3) ? 2 : 1);
      end
    end
  endtask

  task automatic test_lanes();
    for (int pass = 0; pass < 2; pass++) begin
      keycode = 8'h1e;
      for (int c = 0; c < 3; c++) begin
        step();
        checks++;
        if ({lane_hold, lane_press} !== {4'b0001, (pass == 0 && c == 0) ? 4'b0001 : 4'b0000}) begin
          errors++;
          $display("FAIL lane_p%0d_c%0d: hold=%b press=%b expected 0001 %b", pass, c, lane_hold,
                   lane_press, (pass == 0 && c == 0) ? 4'b0001 : 4'b0000);
        end
      end
      keycode = 8'h00; step();
      checks++;
      if (lane_hold !== 4'b0000) begin
        errors++;
        $display("FAIL lane_release_%0d: hold=%b expected 0000", pass, lane_hold);
      end
      end_ = 1'b1; step(); end_ = 1'b0;
    end
  endtask

  task automatic test_start_end();
    start_ = 1'b1; step(); start_ = 1'b0;
    start_ = 1'b1; end_ = 1'b1; step();
    checks++;
    if ({running, paused} !== 2'b00) begin
      errors++;
      $display("FAIL start_end_run: run=%b pause=%b expected 0 0", running, paused);
    end
    step();
    checks++;
    if ({running, paused} !== 2'b00) begin
      errors++;
      $display("FAIL start_end_idle: run=%b pause=%b expected 0 0", running, paused);
    end
    start_ = 1'b0; end_ = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start_ = 1'b1; step(); start_ = 1'b0;
    repeat (6) step();
    keycode = 8'h1e; step();
    checks++;
    if ({running, beat, lane_hold} !== {1'b1, 16'd1, 4'b0001}) begin
      errors++;
      $display("FAIL pre_reset: run=%b beat=%0d hold=%b expected 1 1 0001", running, beat, lane_hold);
    end
    Reset = 1'b1; step(); Reset = 1'b0; keycode = 8'h00;
    checks++;
    if ({running, paused, shift, beat, lane_hold, lane_press} !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid_run: run=%b pause=%b shift=%b beat=%0d hold=%b press=%b expected all 0",
               running, paused, shift, beat, lane_hold, lane_press);
    end
  endtask

  task automatic test_beat_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int n = 0;
    start_ = 1'b1; step(); start_ = 1'b0;
    for (int c = 0; c < 5 * TP; c++) begin
      step();
      if (shift2 && n < 5) begin
        checks++;
        if (beat2 !== exp_seq[n]) begin
          errors++;
          $display("FAIL beat_wrap_%0d: beat=%0d expected %0d", n, beat2, exp_seq[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL beat_wrap_count: shifts=%0d expected 5", n);
    end
    end_ = 1'b1; step(); end_ = 1'b0;
  endtask

  task automatic test_random();
    logic [27:0] exp_v;
    logic [13:0] exp2;
    Reset = 1'b1; step(); Reset = 1'b0;
    for (int n = 0; n < 800; n++) begin
      Reset  = ($urandom_range(0, 99) == 0);
      start_ = ($urandom_range(0, 7) == 0);
      end_   = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 7))
        0, 1:    keycode = 8'h00;
        2:       keycode = 8'h13;
        3:       keycode = 8'h2c;
        4:       keycode = lane_key[$urandom_range(0, 3)];
        7:       keycode = 8'($urandom);
        default: keycode = keycode;
      endcase
      step();
      exp_v = {(m_mode == 1), (m_mode == 2), m_shift, 16'(m_ticks), m_space, m_hold, m_press};
      exp2  = {(m_mode == 1), (m_mode == 2), m_shift, 2'(m_ticks), m_space, m_hold, m_press};
      checks++;
      if ({running, paused, shift, beat, space, lane_hold, lane_press} !== exp_v) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", n,
                 {running, paused, shift, beat, space, lane_hold, lane_press}, exp_v);
      end
      checks++;
      if ({running2, paused2, shift2, beat2, space2, lane_hold2, lane_press2} !== exp2) begin
        errors++;
        $display("FAIL random2_%0d: got %h expected %h", n,
                 {running2, paused2, shift2, beat2, space2, lane_hold2, lane_press2}, exp2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_ticks();
    test_pause();
    test_lanes();
    test_start_end();
    test_reset_mid_run();
    test_beat_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
